// File: rtl/poly_mult_tile_accum.sv
// Tiled polynomial product accumulator.
// It accumulates partial-product tiles that arrive in any order into a
// 2N-entry coefficient buffer. Accumulation is modulo MODULUS, in linear or
// negacyclic mode. The result is streamed out in OUT_LANES-wide beats.
module poly_mult_tile_accum #(
   parameter int unsigned       N          = 128,
   parameter int unsigned       TILE       = 8,
   parameter int unsigned       DATA_WIDTH = 64,
   parameter longint unsigned   MODULUS    = 97,
   parameter int unsigned       OUT_LANES  = 8,
   localparam int unsigned      IDX_W      = $clog2(N / TILE),
   localparam int unsigned      OUT_IDX_W  = $clog2(2 * N)
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    start,
   input  logic                                    mode,
   input  logic                                    part_valid,
   output logic                                    part_ready,
   input  logic [2*TILE-2:0][DATA_WIDTH-1:0]       part_data,
   input  logic [IDX_W-1:0]                        part_a_idx,
   input  logic [IDX_W-1:0]                        part_b_idx,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic [OUT_LANES-1:0][DATA_WIDTH-1:0]    out_data,
   output logic [OUT_IDX_W-1:0]                    out_index,
   output logic                                    out_last,
   output logic                                    busy,
   output logic                                    done
);

   localparam int unsigned LANES     = 2 * TILE - 1;
   localparam int unsigned LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned TILES     = (N / TILE) * (N / TILE);
   localparam int unsigned CNT_W     = $clog2(TILES + 1);
   localparam int unsigned BEATS_LIN = 2 * N / OUT_LANES;
   localparam int unsigned BEATS_NEG = N / OUT_LANES;
   localparam int unsigned BEAT_W    = $clog2(BEATS_LIN + 1);
   localparam logic [DATA_WIDTH:0] Q_EXT = (DATA_WIDTH + 1)'(MODULUS);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

   state_t                               state_q, state_nxt;
   logic [2*N-1:0][DATA_WIDTH-1:0]       coef_q, coef_nxt;
   logic                                 mode_q;
   logic [CNT_W-1:0]                     cnt_q;
   logic [BEAT_W-1:0]                    beat_q;
   logic                                 last_beat;
   int                                   base, off, off2;

   function automatic logic [DATA_WIDTH-1:0] mod_add(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
      logic [DATA_WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= Q_EXT) s = s - Q_EXT;
      return s[DATA_WIDTH-1:0];
   endfunction

   // A borrow shows up in the extra top bit; adding Q brings the result back into range.
   function automatic logic [DATA_WIDTH-1:0] mod_sub(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
      logic [DATA_WIDTH:0] d;
      d = {1'b0, a} - {1'b0, b};
      if (d[DATA_WIDTH]) d = d + Q_EXT;
      return d[DATA_WIDTH-1:0];
   endfunction

   assign last_beat = (beat_q == (mode_q ? BEAT_W'(BEATS_NEG - 1) : BEAT_W'(BEATS_LIN - 1)));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_IDLE:  if (start) state_nxt = S_ACCUM;
         S_ACCUM: if (part_valid && cnt_q == CNT_W'(TILES - 1)) state_nxt = S_DRAIN;
         S_DRAIN: if (out_ready && last_beat) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Handshake and status outputs decoded from state
   always_comb begin
      part_ready = (state_q == S_ACCUM);
      out_valid  = (state_q == S_DRAIN);
      out_last   = (state_q == S_DRAIN) && last_beat;
      busy       = (state_q != S_IDLE);
      done       = (state_q == S_DONE);
   end

   // Per-entry update: each buffer entry pulls its own lane(s). In negacyclic mode an
   // entry can receive an add at p and a subtract from p+N within the same tile.
   always_comb begin
      coef_nxt = coef_q;
      base     = (int'(part_a_idx) + int'(part_b_idx)) * int'(TILE);
      off      = 0;
      off2     = 0;
      for (int unsigned i = 0; i < 2 * N; i++) begin
         off  = int'(i) - base;
         off2 = off + int'(N);
         if (!mode_q) begin
            if (off >= 0 && off < int'(LANES))
               coef_nxt[OUT_IDX_W'(i)] = mod_add(coef_q[OUT_IDX_W'(i)], part_data[LANE_W'(off)]);
         end else if (i < N) begin
            if (off >= 0 && off < int'(LANES))
               coef_nxt[OUT_IDX_W'(i)] = mod_add(coef_q[OUT_IDX_W'(i)], part_data[LANE_W'(off)]);
            if (off2 >= 0 && off2 < int'(LANES))
               coef_nxt[OUT_IDX_W'(i)] = mod_sub(coef_nxt[OUT_IDX_W'(i)], part_data[LANE_W'(off2)]);
         end
      end
   end

   // Buffer, latched mode, tile counter and beat pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         coef_q <= '0;
         mode_q <= 1'b0;
         cnt_q  <= '0;
         beat_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (start) begin
               coef_q <= '0;
               mode_q <= mode;
               cnt_q  <= '0;
               beat_q <= '0;
            end
            S_ACCUM: if (part_valid) begin
               coef_q <= coef_nxt;
               cnt_q  <= cnt_q + CNT_W'(1);
            end
            S_DRAIN: if (out_ready) beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
            default: ;
         endcase
      end
   end

   // Output beat view of the buffer
   always_comb begin
      out_index = OUT_IDX_W'(beat_q * OUT_LANES);
      for (int unsigned j = 0; j < OUT_LANES; j++)
         out_data[j] = coef_q[OUT_IDX_W'(beat_q * OUT_LANES + j)];
   end

endmodule
